// File: rtl/axil_uart_rd_slave.sv
// axil_uart_rd_slave: AXI4-Lite read-only slave exposing a UART RX byte FIFO and status
module axil_uart_rd_slave #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [7:0]        rx_byte,
    input  logic              rx_byte_valid,
    input  logic              rx_irq_en,
    output logic              uart_irq
);
    localparam int AW = CNT_W - 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state_q, state_d;
    logic              arready_q, arready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovr_q, ovr_d, irq_q, irq_d;
    logic              hs, addr_ok, is_rx, is_st, empty, full, push, pop;

    assign hs      = s_axi_arvalid && arready_q;
    assign addr_ok = (s_axi_araddr[31:4] == 28'd0) && (s_axi_araddr[1:0] == 2'b00);
    assign is_rx   = addr_ok && (s_axi_araddr[3:2] == 2'd0);
    assign is_st   = addr_ok && (s_axi_araddr[3:2] == 2'd1);
    assign empty   = count_q == '0;
    assign full    = count_q == CNT_W'(FIFO_DEPTH);
    // A pop frees a slot in the same edge, so a push into a full FIFO alongside a pop succeeds.
    assign pop     = hs && is_rx && !empty;
    assign push    = rx_byte_valid && (!full || pop);
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    // A fresh overrun in the same cycle as a STATUS read must survive the clear.
    assign ovr_d   = (rx_byte_valid && full && !pop) || (ovr_q && !(hs && is_st));
    assign irq_d   = (rx_irq_en && (count_d != '0)) || ovr_d;

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = state_q == RESP;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign uart_irq      = irq_q;

    // Read FSM next state and response capture at the AR handshake.
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (state_q == IDLE) begin
            arready_d = 1'b1;
            if (hs) begin
                state_d   = RESP;
                arready_d = 1'b0;
                rdata_d   = is_rx ? (empty ? 32'h8000_0000 : {24'd0, mem_q[rptr_q]}) :
                            is_st ? {20'd0, 8'(count_q), 1'b0, ovr_q, full, empty} : 32'd0;
                rresp_d   = (is_rx || is_st) ? 2'b00 : 2'b10;
            end
        end else if (s_axi_rready) begin
            state_d   = IDLE;
            arready_d = 1'b1;
        end
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            wptr_q    <= push ? wptr_q + AW'(1) : wptr_q;
            rptr_q    <= pop ? rptr_q + AW'(1) : rptr_q;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= rx_byte;
    end
endmodule

// File: tb/tb_axil_uart_rd_slave.sv
// tb_axil_uart_rd_slave: directed self-checking bench for axil_uart_rd_slave
module tb_axil_uart_rd_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic        irq_en = 1'b0;
    logic        irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    axil_uart_rd_slave #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .rx_byte(rx_byte), .rx_byte_valid(rx_valid), .rx_irq_en(irq_en), .uart_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Waits for arready (bounded), handshakes, samples the response one cycle later, completes it.
    task automatic axi_read(input logic [31:0] a, input logic [7:0] pb, input bit do_push,
                            output logic [31:0] d, output logic [1:0] r, output bit lat_ok);
        bit got;
        got = 1'b0;
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (arready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (do_push) begin
            rx_byte  = pb;
            rx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        arvalid  = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        d      = rdata;
        r      = rresp;
        lat_ok = got && rvalid;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({arready, rvalid, rdata, rresp, irq} !== 36'd0) $display("FAIL reset_outputs: got %h required 0", {arready, rvalid, rdata, rresp, irq});
        else pass_cnt++;
        rst_n = 1'b1;
        total_cnt++;
        if (arready !== 1'b0) $display("FAIL reset_release_pre_edge: arready %b required 0", arready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (arready !== 1'b1) $display("FAIL reset_first_edge: arready %b required 1", arready);
        else pass_cnt++;
    endtask

    task automatic test_basic_read();
        logic [31:0] d;
        logic [1:0]  r;
        bit          l;
        push(8'h5A);
        axi_read(32'h4, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0010) $display("FAIL basic_status_one: rdata %h required 00000010", d);
        else pass_cnt++;
        axi_read(32'h0, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if ({l, r, d} !== {1'b1, 2'b00, 32'h0000_005A}) $display("FAIL basic_rxdata: lat %b resp %b rdata %h required 1 00 0000005a", l, r, d);
        else pass_cnt++;
        axi_read(32'h4, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0001) $display("FAIL basic_status_empty: rdata %h required 00000001", d);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  r;
        bit          l;
        logic [31:0] addrs [5] = '{32'h0, 32'h10, 32'h2, 32'h8, 32'hC};
        logic [31:0] exp_d [5] = '{32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [1:0]  exp_r [5] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 5; i++) begin
            axi_read(addrs[i], 8'h0, 1'b0, d, r, l);
            total_cnt++;
            if ({r, d} !== {exp_r[i], exp_d[i]}) $display("FAIL err_addr_%h: resp %b rdata %h required %b %h", addrs[i], r, d, exp_r[i], exp_d[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [1:0]  r;
        bit          l;
        for (int i = 1; i <= 9; i++) push(8'(i));
        repeat (2) @(negedge clk);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL ovr_irq: irq %b required 1", irq);
        else pass_cnt++;
        axi_read(32'h4, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0086) $display("FAIL ovr_status1: rdata %h required 00000086", d);
        else pass_cnt++;
        axi_read(32'h4, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0082) $display("FAIL ovr_status2: rdata %h required 00000082", d);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL ovr_irq_cleared: irq %b required 0", irq);
        else pass_cnt++;
        irq_en = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_en_nonempty: irq %b required 1", irq);
        else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            axi_read(32'h0, 8'h0, 1'b0, d, r, l);
            total_cnt++;
            if ({r, d} !== {2'b00, 32'(i)}) $display("FAIL ovr_read_%0d: resp %b rdata %h required 00 %h", i, r, d, 32'(i));
            else pass_cnt++;
        end
        repeat (2) @(negedge clk);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_empty: irq %b required 0", irq);
        else pass_cnt++;
        irq_en = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        bit          l;
        push(8'h33);
        rready = 1'b0;
        @(negedge clk);
        araddr  = 32'h0;
        arvalid = 1'b1;
        @(posedge clk);
        #1;
        araddr = 32'h4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({rvalid, arready, rdata} !== {1'b1, 1'b0, 32'h0000_0033}) $display("FAIL hold_cycle_%0d: rvalid %b arready %b rdata %h required 1 0 00000033", i, rvalid, arready, rdata);
            else pass_cnt++;
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({rvalid, arready} !== 2'b01) $display("FAIL hold_release: rvalid %b arready %b required 0 1", rvalid, arready);
        else pass_cnt++;
        axi_read(32'h4, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0001) $display("FAIL hold_status: rdata %h required 00000001", d);
        else pass_cnt++;
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] d;
        logic [1:0]  r;
        bit          l;
        axi_read(32'h0, 8'h77, 1'b1, d, r, l);
        total_cnt++;
        if (d !== 32'h8000_0000) $display("FAIL empty_simul_read: rdata %h required 80000000", d);
        else pass_cnt++;
        axi_read(32'h4, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0010) $display("FAIL empty_simul_status: rdata %h required 00000010", d);
        else pass_cnt++;
        axi_read(32'h0, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0077) $display("FAIL empty_simul_byte: rdata %h required 00000077", d);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        axi_read(32'h0, 8'hAA, 1'b1, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0010) $display("FAIL full_simul_read: rdata %h required 00000010", d);
        else pass_cnt++;
        axi_read(32'h4, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0082) $display("FAIL full_simul_status: rdata %h required 00000082", d);
        else pass_cnt++;
        for (int i = 1; i < 8; i++) begin
            axi_read(32'h0, 8'h0, 1'b0, d, r, l);
            total_cnt++;
            if (d !== 32'h10 + 32'(i)) $display("FAIL full_drain_%0d: rdata %h required %h", i, d, 32'h10 + 32'(i));
            else pass_cnt++;
        end
        axi_read(32'h0, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_00AA) $display("FAIL full_last_aa: rdata %h required 000000aa", d);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_resp();
        logic [31:0] d;
        logic [1:0]  r;
        bit          l;
        push(8'h44);
        rready = 1'b0;
        @(negedge clk);
        araddr  = 32'h0;
        arvalid = 1'b1;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (rvalid !== 1'b1) $display("FAIL rst_mid_pending: rvalid %b required 1", rvalid);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({rvalid, arready, rdata, irq} !== 35'd0) $display("FAIL rst_mid_async: rvalid %b arready %b rdata %h irq %b required all 0", rvalid, arready, rdata, irq);
        else pass_cnt++;
        rready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({arready, rvalid} !== 2'b10) $display("FAIL rst_mid_arready: arready %b rvalid %b required 1 0", arready, rvalid);
        else pass_cnt++;
        axi_read(32'h4, 8'h0, 1'b0, d, r, l);
        total_cnt++;
        if (d !== 32'h0000_0001) $display("FAIL rst_mid_status: rdata %h required 00000001", d);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_errors();
        test_overrun();
        test_backpressure();
        test_simul_push_pop();
        test_reset_mid_resp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/axil_uart_rd_slave.md
AXIL_UART_RD_SLAVE -- requirements
Module: axil_uart_rd_slave

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, RX byte FIFO depth; power of two, 2..64.
REQ-002 SHALL have parameter CNT_W, default 4, occupancy count width; equals log2(FIFO_DEPTH)+1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_axi_araddr  input  32  read address.
REQ-006 SHALL have port s_axi_arvalid  input  1  address valid.
REQ-007 SHALL have port s_axi_arready  output  1  address accept.
REQ-008 SHALL have port s_axi_rdata  output  32  read data.
REQ-009 SHALL have port s_axi_rresp  output  2  response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-010 SHALL have port s_axi_rvalid  output  1  read data valid.
REQ-011 SHALL have port s_axi_rready  input  1  read data accept.
REQ-012 SHALL have port rx_byte  input  8  byte from UART receiver.
REQ-013 SHALL have port rx_byte_valid  input  1  one-cycle push strobe for rx_byte.
REQ-014 SHALL have port rx_irq_en  input  1  interrupt enable, supplied by the write-side register block.
REQ-015 SHALL have port uart_irq  output  1  level interrupt.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (arready=1, rvalid=0) and RESP (arready=0, rvalid=1).
REQ-017 SHALL move IDLE->RESP on arvalid&&arready, registering rdata/rresp in that same edge; rvalid rises the cycle after the AR handshake.
REQ-018 SHALL hold rdata/rresp/rvalid stable in RESP until rready; RESP->IDLE on rvalid&&rready. One outstanding read, minimum two cycles per read.
REQ-019 SHALL decode araddr[3:0] at the AR handshake. 0x0 RXDATA: {empty,23'b0,byte}. 0x4 STATUS: {16'b0,4'b0,count[CNT_W-1:0] zero-extended to bits[11:4]... bits[11:4]=count,1'b0,overrun,full,empty} in bits[3:0]={0,overrun,full,empty}.
REQ-020 SHALL return rdata=0, rresp=SLVERR for araddr[1:0]!=0, araddr[31:4]!=0, or offsets 0x8/0xC; no side effects.
REQ-021 SHALL pop the FIFO at the AR handshake of an RXDATA read when not empty (rresp OKAY); when empty, return 32'h8000_0000, OKAY, no pop.
REQ-022 SHALL push rx_byte on rx_byte_valid when not full; when full, drop byte and set sticky overrun.
REQ-023 SHALL treat simultaneous push and pop when full as both succeeding, count unchanged, no overrun.
REQ-024 SHALL treat simultaneous push and RXDATA pop attempt when empty as: read returns empty (32'h8000_0000), pushed byte stored, count becomes 1.
REQ-025 SHALL clear overrun at the AR handshake of a STATUS read (value read shows pre-clear state); a same-cycle new overrun wins (stays 1).
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-027 SHALL drive uart_irq registered: (rx_irq_en && !empty) || overrun, updated one cycle after the causing event.

Reset
REQ-028 SHALL, while rst_n=0, force arready=0, rvalid=0, rdata=0, rresp=0, uart_irq=0, FIFO empty, count=0, overrun=0, FSM=IDLE.
REQ-029 SHALL drive arready=1 on the first rising clk after rst_n deasserts; reset mid-RESP discards the pending response.

Verification
REQ-030 SHALL be shown: push 0x5A, read 0x0 with rready=1 -> rvalid one cycle after handshake, rdata=0x0000_005A, OKAY, count 0.
REQ-031 SHALL be shown: read 0x0 on empty FIFO -> rdata=0x8000_0000, OKAY; read 0x10 -> rdata=0, rresp=2'b10; read 0x2 -> SLVERR.
REQ-032 SHALL be shown: 9 pushes 0x01..0x09, depth 8 -> STATUS=0x0000_0086 (count 8, overrun, full), irq=1; second STATUS read -> 0x0000_0082; 8 RXDATA reads return 0x01..0x08.
REQ-033 SHALL be shown: rready held 0 for 5 cycles in RESP -> rdata/rvalid stable, arready=0, extra arvalid not accepted.
REQ-034 SHALL be shown: FIFO full, push 0xAA same cycle as RXDATA handshake -> no overrun, count stays 8, 0xAA read last.
REQ-035 SHALL be shown: rst_n pulsed low during RESP -> rvalid=0 immediately, arready=1 after first post-reset edge, STATUS=0x0000_0001.
